axilite_master_32x32: RTL and testbench

AXILITE_MASTER_32X32 -- requirements
Module: axilite_master_32x32

---
 rtl/axilite_master_32x32_pkg.sv | 25 ++
 rtl/axilite_slave_mmap_32x32_r4.sv | 101 ++++++++++
 rtl/axilite_master_32x32.sv | 169 ++++++++++++++++
 tb/tb_axilite_master_32x32.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axilite_master_32x32_pkg.sv
// Shared definitions for the AXI4-Lite master and its companion slave.
// Holds the bus width constants, the BRESP/RRESP codes, and the
// write/read FSM state enums used by the master.
package axilite_master_32x32_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/axilite_slave_mmap_32x32_r4.sv
// Minimal AXI4-Lite slave with four 32-bit registers, selected by
// address bits [15:14] (0x10000, 0x14000, 0x18000, 0x1C000).
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*     : write address, write data and write response channels
//   S_AXI_AR*/R*        : read address and read data channels
// Every response is OKAY; all other address bits are ignored.
module axilite_slave_mmap_32x32_r4
    import axilite_master_32x32_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [AXI_DATA_W-1:0] S_AXI_WDATA,
    input  logic [AXI_STRB_W-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [AXI_DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY
);

    logic [AXI_DATA_W-1:0] regs_q [4];
    logic                  awready_q;
    logic                  bvalid_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [AXI_DATA_W-1:0] rdata_q;

    logic                  aw_hs;
    logic                  ar_hs;
    logic [1:0]            wsel;
    logic [1:0]            rsel;
    logic                  unused_bits;

    assign wsel  = S_AXI_AWADDR[15:14];
    assign rsel  = S_AXI_ARADDR[15:14];
    // The ready pulse is only raised while the master holds VALID, so the
    // handshake is the registered ready qualified by the still-high VALIDs.
    assign aw_hs = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign ar_hs = arready_q && S_AXI_ARVALID;

    assign unused_bits = ^{S_AXI_AWADDR[31:16], S_AXI_AWADDR[13:0],
                           S_AXI_ARADDR[31:16], S_AXI_ARADDR[13:0],
                           S_AXI_AWPROT, S_AXI_ARPROT};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            // One-cycle pulse: blocked on the cycle after it fires and
            // while a response is still outstanding.
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
            if (aw_hs) begin
                for (int b = 0; b < AXI_STRB_W; b++) begin
                    if (S_AXI_WSTRB[b]) regs_q[wsel][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
                bvalid_q <= 1'b1;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (ar_hs) begin
                rvalid_q <= 1'b1;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Read data is only observed while RVALID is high, so it needs no reset.
    always_ff @(posedge clock) begin
        if (ar_hs) rdata_q <= regs_q[rsel];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;

endmodule

// File: rtl/axilite_master_32x32.sv
// AXI4-Lite master with independent single-beat write and read engines.
// Ports:
//   clock, reset                 : single clock, synchronous active-high reset
//   W_ADDR/W_DATA/W_EN           : write command; W_READY high when idle,
//                                  W_RESP holds the last BRESP
//   R_ADDR/R_EN                  : read command; R_READY high when idle,
//                                  R_DATA/R_RESP hold the last RDATA/RRESP
//   M_AXI_AW*/W*/B*, M_AXI_AR*/R*: AXI4-Lite master channels
// Every bus VALID/READY is driven from registered state only.
module axilite_master_32x32
    import axilite_master_32x32_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   W_ADDR,
    input  logic [DATA_W-1:0]   W_DATA,
    input  logic                W_EN,
    output logic                W_READY,
    output logic [1:0]          W_RESP,
    input  logic [ADDR_W-1:0]   R_ADDR,
    input  logic                R_EN,
    output logic [DATA_W-1:0]   R_DATA,
    output logic                R_READY,
    output logic [1:0]          R_RESP,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    wr_state_e           wr_state_q, wr_state_d;
    logic                awvalid_q,  awvalid_d;
    logic                wvalid_q,   wvalid_d;
    logic [ADDR_W-1:0]   awaddr_q,   awaddr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [1:0]          wresp_q,    wresp_d;

    rd_state_e           rd_state_q, rd_state_d;
    logic [ADDR_W-1:0]   araddr_q,   araddr_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic [1:0]          rresp_q,    rresp_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wresp_q    <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wresp_q    <= wresp_d;
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Write engine: AW and W complete independently; the response phase
    // starts only once both VALIDs have been retired.
    always_comb begin
        wr_state_d = wr_state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wresp_d    = wresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (W_EN) begin
                    awaddr_d   = W_ADDR;
                    wdata_d    = W_DATA;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_state_d = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                awvalid_d = awvalid_q && !M_AXI_AWREADY;
                wvalid_d  = wvalid_q && !M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    wresp_d    = M_AXI_BRESP;
                    wr_state_d = WR_IDLE;
                end
            end
            default: begin
                awvalid_d  = 1'b0;
                wvalid_d   = 1'b0;
                wr_state_d = WR_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (R_EN) begin
                    araddr_d   = R_ADDR;
                    rd_state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d    = M_AXI_RDATA;
                    rresp_d    = M_AXI_RRESP;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign W_READY       = (wr_state_q == WR_IDLE);
    assign W_RESP        = wresp_q;
    assign R_READY       = (rd_state_q == RD_IDLE);
    assign R_DATA        = rdata_q;
    assign R_RESP        = rresp_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (wr_state_q == WR_RESP);
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (rd_state_q == RD_ADDR);
    assign M_AXI_RREADY  = (rd_state_q == RD_DATA);

endmodule

// File: tb/tb_axilite_master_32x32.sv
module tb_axilite_master_32x32;
    import axilite_master_32x32_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] W_ADDR, W_DATA, R_ADDR, R_DATA;
    logic        W_EN, W_READY, R_EN, R_READY;
    logic [1:0]  W_RESP, R_RESP;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clock = ~clock;

    axilite_master_32x32 #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN), .W_READY(W_READY), .W_RESP(W_RESP),
        .R_ADDR(R_ADDR), .R_EN(R_EN), .R_DATA(R_DATA), .R_READY(R_READY), .R_RESP(R_RESP),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    axilite_slave_mmap_32x32_r4 slv (
        .clock(clock), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [4];
    logic [1:0]  exp_wq [$];
    logic [33:0] exp_rq [$];
    logic [33:0] e_r;
    logic [1:0]  e_w;
    logic [31:0] last_rd;
    logic        prev_w, prev_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: an idle edge (READY 0 -> 1) outside reset is a completion.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (prev_w === 1'b0 && W_READY === 1'b1) begin
                if (exp_wq.size() == 0) check("w_spurious_done", 64'(exp_wq.size()), 64'd1);
                else begin
                    e_w = exp_wq.pop_front();
                    check("w_resp", W_RESP, e_w);
                end
            end
            if (prev_r === 1'b0 && R_READY === 1'b1) begin
                if (exp_rq.size() == 0) check("r_spurious_done", 64'(exp_rq.size()), 64'd1);
                else begin
                    e_r = exp_rq.pop_front();
                    check("r_resp_data", {R_RESP, R_DATA}, e_r);
                end
            end
        end
        prev_w <= W_READY;
        prev_r <= R_READY;
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        cyc = 0;
        while (W_READY !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
        check("w_idle_before_issue", W_READY, 1);
        W_ADDR = a; W_DATA = d; W_EN = 1'b1;
        ref_mem[a[15:14]] = d;
        exp_wq.push_back(RESP_OKAY);
        @(negedge clock);
        W_EN = 1'b0;
        check("w_ready_low_after_en", W_READY, 0);
        cyc = 1;
        while (W_READY !== 1'b1 && cyc < 12) begin @(negedge clock); cyc++; end
        check("w_latency_le10", 64'(cyc <= 10), 1);
    endtask

    task automatic rd(input logic [31:0] a);
        int cyc;
        cyc = 0;
        while (R_READY !== 1'b1 && cyc < 20) begin @(negedge clock); cyc++; end
        check("r_idle_before_issue", R_READY, 1);
        R_ADDR = a; R_EN = 1'b1;
        exp_rq.push_back({RESP_OKAY, ref_mem[a[15:14]]});
        last_rd = ref_mem[a[15:14]];
        @(negedge clock);
        R_EN = 1'b0;
        check("r_ready_low_after_en", R_READY, 0);
        cyc = 1;
        while (R_READY !== 1'b1 && cyc < 12) begin @(negedge clock); cyc++; end
        check("r_latency_le10", 64'(cyc <= 10), 1);
    endtask

    function automatic logic [31:0] reg_addr(input int idx);
        logic [31:0] a;
        a = 32'h0001_0000;
        a[15:14] = 2'(idx);
        return a;
    endfunction

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[15:14] = 2'(idx);
        return a;
    endfunction

    task automatic check_reset_state();
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid",  wvalid,  0);
        check("rst_bready",  bready,  0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready",  rready,  0);
        check("rst_awaddr",  awaddr,  0);
        check("rst_araddr",  araddr,  0);
        check("rst_wdata",   wdata,   0);
        check("rst_r_data",  R_DATA,  0);
        check("rst_w_resp",  W_RESP,  0);
        check("rst_r_resp",  R_RESP,  0);
        check("rst_w_ready", W_READY, 1);
        check("rst_r_ready", R_READY, 1);
        check("const_prot",  {awprot, arprot}, 0);
        check("const_wstrb", wstrb, 4'hF);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pats [4];
        int wi, ri;
        reset = 1'b1; W_EN = 0; R_EN = 0;
        W_ADDR = 0; W_DATA = 0; R_ADDR = 0; last_rd = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state();

        // Registers read zero out of reset
        for (int i = 0; i < 4; i++) rd(reg_addr(i));

        // Single write/read-back per register
        wr(reg_addr(0), 32'hDEADBEEF); rd(reg_addr(0));
        wr(reg_addr(1), 32'h12345678); rd(reg_addr(1));
        wr(reg_addr(2), 32'hABCDEF01); rd(reg_addr(2));
        wr(reg_addr(3), 32'h87654321); rd(reg_addr(3));

        // Cross-talk: all writes first, then all reads
        pats[0] = 32'hAAAAAAAA; pats[1] = 32'h55555555;
        pats[2] = 32'hFFFFFFFF; pats[3] = 32'h00000000;
        for (int i = 0; i < 4; i++) wr(reg_addr(i), pats[i]);
        for (int i = 0; i < 4; i++) rd(reg_addr(i));

        // Outputs hold their last captured value while idle
        repeat (3) @(negedge clock);
        check("r_data_hold", R_DATA, last_rd);

        // Reset in the middle of a write abandons it and clears the registers
        @(negedge clock);
        W_ADDR = reg_addr(1); W_DATA = 32'h11112222; W_EN = 1'b1;
        @(negedge clock);
        W_EN = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        @(negedge clock);
        check("mid_rst_w_ready", W_READY, 1);
        check("mid_rst_r_ready", R_READY, 1);
        check("mid_rst_awvalid", awvalid, 0);
        for (int i = 0; i < 4; i++) rd(reg_addr(i));

        // Nibble/halfword patterns with back-to-back reads
        pats[0] = 32'h0F0F0F0F; pats[1] = 32'hF0F0F0F0;
        pats[2] = 32'hFFFF0000; pats[3] = 32'h0000FFFF;
        for (int i = 0; i < 4; i++) wr(reg_addr(i), pats[i]);
        for (int i = 0; i < 4; i++) rd(reg_addr(i));
        for (int i = 3; i >= 0; i--) rd(reg_addr(i));

        // W_EN while busy: second command must be dropped
        @(negedge clock);
        W_ADDR = reg_addr(0); W_DATA = 32'hC0FFEE00; W_EN = 1'b1;
        ref_mem[0] = 32'hC0FFEE00;
        exp_wq.push_back(RESP_OKAY);
        @(negedge clock);
        W_ADDR = reg_addr(1); W_DATA = 32'hBAD0BAD0;
        repeat (2) @(negedge clock);
        check("busy_awaddr_kept", awaddr, reg_addr(0));
        check("busy_wdata_kept",  wdata,  32'hC0FFEE00);
        W_EN = 1'b0;
        for (int c = 0; c < 10 && W_READY !== 1'b1; c++) @(negedge clock);
        check("busy_write_done", W_READY, 1);
        rd(reg_addr(0));
        rd(reg_addr(1));

        // Concurrent write and read to different registers
        fork
            wr(reg_addr(2), 32'h13579BDF);
            rd(reg_addr(3));
        join
        rd(reg_addr(2));

        // Randomized traffic against the register model
        for (int n = 0; n < 60; n++) begin
            wi = $urandom_range(0, 3);
            ri = (wi + 1 + $urandom_range(0, 2)) % 4;
            case ($urandom_range(0, 2))
                0: wr(rand_addr(wi), $urandom);
                1: rd(rand_addr(ri));
                default: fork
                    wr(rand_addr(wi), $urandom);
                    rd(rand_addr(ri));
                join
            endcase
        end

        // Random values survive a reset pulse as zeros
        pulse_reset();
        for (int i = 0; i < 4; i++) rd(rand_addr(i));

        repeat (5) @(negedge clock);
        check("w_queue_drained", 64'(exp_wq.size()), 0);
        check("r_queue_drained", 64'(exp_rq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
